// File: rtl/card_dealer_if.sv
// Deal-request bus between the game controller (master) and the card dealer (slave).
interface card_dealer_if;
  logic       pip;
  logic       reshuffle;
  logic [3:0] number;
  logic       busy;
  logic       deck_empty;
  logic [5:0] cards_left;

  modport master (
    output pip,
    output reshuffle,
    input  number,
    input  busy,
    input  deck_empty,
    input  cards_left
  );

  modport slave (
    input  pip,
    input  reshuffle,
    output number,
    output busy,
    output deck_empty,
    output cards_left
  );
endinterface

// File: rtl/card_dealer.sv
// Card source: fills a 13*SUITS deck, Fisher-Yates shuffles it with a Galois LFSR, deals without replacement.
// Define CARD_DEALER_NOSHUFFLE_EN to skip the shuffle and deal in fill order (1..13, 1..13, ...).
module card_dealer #(
  parameter int          SUITS     = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic          clk,
  input  logic          rst_n,
  card_dealer_if.slave  bus
);

  localparam int          DECK_SIZE = 13 * SUITS;
  localparam logic [5:0]  DECK_N    = 6'(DECK_SIZE);
  localparam logic [5:0]  DECK_LAST = 6'(DECK_SIZE - 1);
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ST_FILL    = 2'd0,
    ST_SHUFFLE = 2'd1,
    ST_READY   = 2'd2
  } state_t;

  state_t      state_r;
  logic [15:0] lfsr_r;
  logic [3:0]  deck_r [0:DECK_SIZE-1];
  logic [5:0]  ptr_r;
  logic [5:0]  fill_idx_r;
  logic [3:0]  rank_r;
  logic [5:0]  idx_r;
  logic [3:0]  number_r;
  logic        busy_r;
  logic        deck_empty_r;
  logic [5:0]  cards_left_r;
  logic [5:0]  cand_s;

  // Right-shifting Galois step for x^16+x^14+x^13+x^11+1.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic [15:0] shifted;
    shifted = v >> 1;
    return v[0] ? (shifted ^ LFSR_TAPS) : shifted;
  endfunction

  assign cand_s = lfsr_r[5:0];

  // Free-running random source; deliberately not restarted by reshuffle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_r <= LFSR_SEED;
    end else begin
      lfsr_r <= lfsr_step(lfsr_r);
    end
  end

  // Dealer FSM: deck storage, shuffle index, deal pointer and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_FILL;
      number_r     <= 4'd0;
      busy_r       <= 1'b1;
      deck_empty_r <= 1'b0;
      cards_left_r <= 6'd0;
      ptr_r        <= 6'd0;
      fill_idx_r   <= 6'd0;
      rank_r       <= 4'd1;
      idx_r        <= 6'd0;
      for (int k = 0; k < DECK_SIZE; k++) begin
        deck_r[k] <= 4'd0;
      end
    end else begin
      number_r <= 4'd0;
      if (bus.reshuffle) begin
        // Reshuffle outranks any deal request in the same cycle.
        state_r      <= ST_FILL;
        busy_r       <= 1'b1;
        deck_empty_r <= 1'b0;
        cards_left_r <= 6'd0;
        ptr_r        <= 6'd0;
        fill_idx_r   <= 6'd0;
        rank_r       <= 4'd1;
      end else begin
        case (state_r)
          ST_FILL: begin
            deck_r[fill_idx_r] <= rank_r;
            rank_r <= (rank_r == 4'd13) ? 4'd1 : (rank_r + 4'd1);
            if (fill_idx_r == DECK_LAST) begin
              fill_idx_r <= 6'd0;
`ifdef CARD_DEALER_NOSHUFFLE_EN
              state_r      <= ST_READY;
              busy_r       <= 1'b0;
              ptr_r        <= 6'd0;
              cards_left_r <= DECK_N;
`else
              state_r <= ST_SHUFFLE;
              idx_r   <= DECK_LAST;
`endif
            end else begin
              fill_idx_r <= fill_idx_r + 6'd1;
            end
          end

          ST_SHUFFLE: begin
            // Out-of-range candidates are simply retried on the next LFSR value.
            if (cand_s <= idx_r) begin
              deck_r[idx_r]  <= deck_r[cand_s];
              deck_r[cand_s] <= deck_r[idx_r];
              if (idx_r == 6'd1) begin
                state_r      <= ST_READY;
                busy_r       <= 1'b0;
                ptr_r        <= 6'd0;
                cards_left_r <= DECK_N;
              end else begin
                idx_r <= idx_r - 6'd1;
              end
            end
          end

          ST_READY: begin
            if (bus.pip && !deck_empty_r && (cards_left_r != 6'd0)) begin
              number_r     <= deck_r[ptr_r];
              ptr_r        <= ptr_r + 6'd1;
              cards_left_r <= cards_left_r - 6'd1;
              if (ptr_r == DECK_LAST) begin
                deck_empty_r <= 1'b1;
              end
            end
          end

          default: begin
            state_r      <= ST_FILL;
            busy_r       <= 1'b1;
            deck_empty_r <= 1'b0;
            cards_left_r <= 6'd0;
            ptr_r        <= 6'd0;
            fill_idx_r   <= 6'd0;
            rank_r       <= 4'd1;
          end
        endcase
      end
    end
  end

  assign bus.number     = number_r;
  assign bus.busy       = busy_r;
  assign bus.deck_empty = deck_empty_r;
  assign bus.cards_left = cards_left_r;

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer: a shuffle/deal reference model drives expectations for random pip traffic.
module tb_card_dealer;
  localparam int          SUITS = 4;
  localparam int          DECK  = 13 * SUITS;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic clk = 1'b0;
  logic rst_n;

  card_dealer_if bus ();

  card_dealer #(
    .SUITS     (SUITS),
    .LFSR_SEED (SEED)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [15:0] m_lfsr;
  int          exp_deck [DECK];
  int          exp_cycles;
  int          exp_ptr;
  int          first_obs [$];
  int          hist [14];

  function automatic logic [15:0] adv(input logic [15:0] v);
    logic [15:0] s;
    s = v >> 1;
    if (v[0]) s = s ^ 16'hB400;
    return s;
  endfunction

  // Reference LFSR: the value held here is the one the dealer uses at the next rising edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= SEED;
    else        m_lfsr <= adv(m_lfsr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Build the fresh deck and run Fisher-Yates from the LFSR value seen at the first fill edge.
  task automatic model_shuffle(input logic [15:0] start);
    logic [15:0] v;
    int i, j, tmp;
    v = start;
    for (int k = 0; k < DECK; k++) begin
      exp_deck[k] = (k % 13) + 1;
      v = adv(v);
    end
    exp_cycles = 0;
`ifndef CARD_DEALER_NOSHUFFLE_EN
    i = DECK - 1;
    while (i >= 1 && exp_cycles < 5000) begin
      j = int'(v[5:0]);
      exp_cycles++;
      if (j <= i) begin
        tmp         = exp_deck[i];
        exp_deck[i] = exp_deck[j];
        exp_deck[j] = tmp;
        i--;
      end
      v = adv(v);
    end
`endif
    exp_ptr = 0;
  endtask

  // Called just before the first FILL edge; random pips during busy must be ignored.
  task automatic run_fill_shuffle(input string tag);
    int   cyc;
    logic noisy;
    model_shuffle(m_lfsr);
    cyc   = 0;
    noisy = 1'b0;
    check({tag, " busy_start"}, 32'(bus.busy), 32'd1);
    while (bus.busy === 1'b1 && cyc < 4000) begin
      bus.pip = 1'($urandom_range(0, 1));
      tick();
      cyc++;
      if (bus.number !== 4'd0) noisy = 1'b1;
    end
    bus.pip = 1'b0;
    check({tag, " busy_cycles"}, 32'(cyc), 32'(DECK + exp_cycles));
    check({tag, " number_quiet"}, 32'(noisy), 32'd0);
    check({tag, " cards_left_full"}, 32'(bus.cards_left), 32'(DECK));
    check({tag, " deck_empty_clear"}, 32'(bus.deck_empty), 32'd0);
  endtask

  task automatic deal_once(input string tag);
    int e;
    bus.pip = 1'b1;
    tick();
    bus.pip = 1'b0;
    e = 0;
    if (exp_ptr < DECK) begin
      e = exp_deck[exp_ptr];
      exp_ptr++;
    end
    check({tag, " number"}, 32'(bus.number), 32'(e));
    check({tag, " cards_left"}, 32'(bus.cards_left), 32'(DECK - exp_ptr));
  endtask

  initial begin
    int pips, e;
    logic p;
    rst_n         = 1'b1;
    bus.pip       = 1'b0;
    bus.reshuffle = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("reset busy", 32'(bus.busy), 32'd1);
    check("reset number", 32'(bus.number), 32'd0);
    check("reset deck_empty", 32'(bus.deck_empty), 32'd0);
    check("reset cards_left", 32'(bus.cards_left), 32'd0);
    #20 rst_n = 1'b1;

    run_fill_shuffle("first_run");

    // Random pip traffic until 53 requests have been issued.
    for (int v = 0; v < 14; v++) hist[v] = 0;
    pips = 0;
    while (pips < DECK + 1) begin
      p       = 1'($urandom_range(0, 1));
      bus.pip = p;
      tick();
      e = 0;
      if (p) begin
        pips++;
        if (exp_ptr < DECK) begin
          e = exp_deck[exp_ptr];
          exp_ptr++;
        end
      end
      check("rand number", 32'(bus.number), 32'(e));
      check("rand cards_left", 32'(bus.cards_left), 32'(DECK - exp_ptr));
      check("rand deck_empty", 32'(bus.deck_empty), 32'(exp_ptr == DECK));
      if (bus.number !== 4'd0) begin
        first_obs.push_back(int'(bus.number));
        if (bus.number <= 4'd13) hist[bus.number]++;
      end
    end
    bus.pip = 1'b0;
    for (int v = 1; v <= 13; v++) check("histogram", 32'(hist[v]), 32'(SUITS));
    check("dealt_total", 32'(first_obs.size()), 32'(DECK));
    check("empty cards_left", 32'(bus.cards_left), 32'd0);

    bus.reshuffle = 1'b1;
    tick();
    bus.reshuffle = 1'b0;
    check("reshuffle busy", 32'(bus.busy), 32'd1);
    run_fill_shuffle("second_run");

    // pip held high for three cycles.
    bus.pip = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("held number", 32'(bus.number), 32'(exp_deck[exp_ptr]));
      check("held nonzero", 32'(bus.number != 4'd0), 32'd1);
      exp_ptr++;
    end
    bus.pip = 1'b0;
    tick();
    check("held after", 32'(bus.number), 32'd0);
    check("held cards_left", 32'(bus.cards_left), 32'(DECK - 3));

    // pip and reshuffle together: reshuffle wins.
    bus.pip       = 1'b1;
    bus.reshuffle = 1'b1;
    tick();
    bus.pip       = 1'b0;
    bus.reshuffle = 1'b0;
    check("collide number", 32'(bus.number), 32'd0);
    check("collide busy", 32'(bus.busy), 32'd1);
    run_fill_shuffle("third_run");
    deal_once("third deal");

    // Asynchronous reset while outputs are non-reset values.
    rst_n = 1'b0;
    #1;
    check("async number", 32'(bus.number), 32'd0);
    check("async busy", 32'(bus.busy), 32'd1);
    check("async cards_left", 32'(bus.cards_left), 32'd0);
    #1 rst_n = 1'b1;
    for (int k = 0; k < DECK + 8; k++) tick();
    check("mid_shuffle busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_shuffle reset busy", 32'(bus.busy), 32'd1);
    check("mid_shuffle reset empty", 32'(bus.deck_empty), 32'd0);
    #1 rst_n = 1'b1;
    run_fill_shuffle("post_reset");
    for (int k = 0; k < DECK; k++) begin
      deal_once("replay deal");
      if (k < first_obs.size()) check("replay order", 32'(bus.number), 32'(first_obs[k]));
    end
    check("replay deck_empty", 32'(bus.deck_empty), 32'd1);
    deal_once("replay extra");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/card_dealer.md
Name: card_dealer

Overview:
Card source for the ten-and-a-half game controller. It answers the controller's `pip` deal requests with a `number` card value (1..13), or 0 when no card is delivered. It holds one shuffled deck of 13*SUITS cards, shuffles it in hardware (Fisher-Yates driven by an LFSR), and deals without replacement until the deck is empty or a reshuffle is requested. It runs on the controller's slow logic clock.

Parameters:
- SUITS, 4: copies of each rank 1..13. Legal range 1..4. DECK_SIZE = 13*SUITS, at most 52.
- LFSR_SEED, 16'hACE1: reset value of the 16-bit Galois LFSR (taps x^16+x^14+x^13+x^11+1). Must be nonzero.

Ports:
- clk, input, 1: logic clock (the controller's d_clk). All state changes on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- pip, input, 1: deal request, sampled every cycle.
- reshuffle, input, 1: one-cycle pulse. Discards the remaining deck and rebuilds and reshuffles it.
- number, output, 4: dealt card value 1..13, valid for exactly one cycle. 0 otherwise.
- busy, output, 1: high during FILL and SHUFFLE.
- deck_empty, output, 1: high when all DECK_SIZE cards have been dealt.
- cards_left, output, 6: count of undealt cards.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state=FILL, number=0, busy=1, deck_empty=0, cards_left=0.
  - ptr=0, fill index=0, LFSR=LFSR_SEED.
  - Deck storage is cleared to 0.
- LFSR: advances every cycle in every state except during reset.
- FILL:
  - One card per cycle: deck[k] = (k mod 13)+1, for k = 0..DECK_SIZE-1. Rank comes from a 1..13 wrap counter; no divider.
  - After DECK_SIZE cycles, go to SHUFFLE with i = DECK_SIZE-1.
- SHUFFLE:
  - Each cycle, candidate j = LFSR[5:0].
  - If j <= i: swap deck[i] and deck[j] in the same cycle, then i = i-1.
  - Otherwise retry next cycle with no swap.
  - When a swap completes with i == 1, go to READY with ptr=0, cards_left=DECK_SIZE, busy=0.
- READY, deal rule:
  - Condition: pip=1, deck_empty=0, reshuffle=0.
  - Response: at the next edge, number <= deck[ptr], ptr <= ptr+1, cards_left <= cards_left-1.
  - Latency is 1 cycle. number is 0 in any cycle not immediately following a dealt request.
  - pip held high for N cycles deals N cards, one per cycle, until the deck is empty.
- Empty deck:
  - When ptr reaches DECK_SIZE, deck_empty=1.
  - Further pip is ignored (number stays 0) until reshuffle.
- pip while busy=1: ignored and not queued. number stays 0.
- reshuffle in any state: the next state is FILL.
  - ptr=0, cards_left=0, deck_empty=0, busy=1.
  - The LFSR is not reset, so successive shuffles differ.
- pip and reshuffle in the same cycle: reshuffle wins and no card is dealt.
- Widths:
  - ptr and i are 6-bit.
  - cards_left never wraps: a deal is blocked at 0.
  - number is always within 0..13.

Optional Feature:
- Macro: CARD_DEALER_NOSHUFFLE_EN
- Defined: the SHUFFLE state is bypassed. FILL goes directly to READY, and cards are dealt in fill order: 1,2,...,13,1,2,...
- Undefined: full LFSR shuffle as described above. This is the default build.

Test Plan:
1. Reset release, default build:
   - busy=1 for exactly DECK_SIZE FILL cycles plus at least 51 SHUFFLE cycles, then falls.
   - number=0 throughout; cards_left=52 when busy falls.
2. CARD_DEALER_NOSHUFFLE_EN, 13 single-cycle pip pulses after busy=0:
   - number is 1,2,...,13, each one cycle after its pip.
   - cards_left goes from 52 to 39.
3. Default build, 53 pips:
   - The first 52 values form a histogram with each of 1..13 exactly 4 times.
   - deck_empty=1 after the 52nd deal; the 53rd pip gives number=0 and cards_left=0.
4. pip held high 3 cycles in READY:
   - number is nonzero on 3 consecutive cycles, then 0.
   - cards_left decrements by exactly 3.
5. reshuffle and pip in the same cycle in READY:
   - No card is dealt (number=0); busy=1 on the next cycle.
   - After busy falls, cards_left=52 and deck_empty=0.
6. rst_n pulsed low mid-SHUFFLE:
   - Outputs reach their reset values immediately, without waiting for a clock edge.
   - After release, a full FILL+SHUFFLE runs, and the dealt order matches the first post-reset run (same LFSR_SEED).
